// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant,
// encoded grant index and grant-valid flag. An owner keeps the grant
// while it requests; a hold limit forces rotation when others wait.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Last hold count before a waiting requester takes over.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0] state_q,    state_d;
  logic [1:0] ptr_q,      ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] gnt_q,      gnt_d;
  logic [1:0] gnt_idx_q,  gnt_idx_d;
  logic       gnt_vld_q,  gnt_vld_d;

  logic [1:0] owner;
  logic [3:0] others;
  logic [2:0] first_hit;
  logic [2:0] next_hit;

  // One-hot decode of a 2-bit index.
  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Circular scan from start index s; result is {found, index}.
  // Scanned from the farthest offset down so the nearest hit wins.
  function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] s);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = s + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Candidate selection shared by the IDLE and GRANT paths.
  always_comb begin
    owner     = gnt_idx_q;
    others    = req & ~onehot(gnt_idx_q);
    first_hit = search(req, ptr_q);
    next_hit  = search(others, gnt_idx_q + 2'd1);
  end

  // Next-state logic for the grant FSM, pointer and hold counter.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;

    case (state_q)
      ST_IDLE: begin
        if (first_hit[2]) begin
          gnt_d      = onehot(first_hit[1:0]);
          gnt_idx_d  = first_hit[1:0];
          gnt_vld_d  = 1'b1;
          hold_cnt_d = 8'd0;
          state_d    = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (!req[owner]) begin
          // Owner let go: pass straight to the next waiter, never back to owner.
          ptr_d      = owner + 2'd1;
          hold_cnt_d = 8'd0;
          if (next_hit[2]) begin
            gnt_d     = onehot(next_hit[1:0]);
            gnt_idx_d = next_hit[1:0];
            gnt_vld_d = 1'b1;
          end else begin
            gnt_d     = 4'b0000;
            gnt_vld_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end else if (others != 4'b0000) begin
          if (hold_cnt_q >= HOLD_LAST) begin
            // Hold limit reached with someone waiting: force rotation.
            gnt_d      = onehot(next_hit[1:0]);
            gnt_idx_d  = next_hit[1:0];
            gnt_vld_d  = 1'b1;
            ptr_d      = owner + 2'd1;
            hold_cnt_d = 8'd0;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end else begin
          // Sole requester: no pressure to rotate, counter stays cleared.
          hold_cnt_d = 8'd0;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        gnt_d      = 4'b0000;
        gnt_vld_d  = 1'b0;
        hold_cnt_d = 8'd0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd0;
      hold_cnt_q <= 8'd0;
      gnt_q      <= 4'b0000;
      gnt_idx_q  <= 2'd0;
      gnt_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: two instances, hold limit 8 and 4.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req8, req4;
  logic [3:0] gnt8, gnt4;
  logic [1:0] idx8, idx4;
  logic       vld8, vld4;

  int checks = 0;
  int errors = 0;

  rr_arbiter4 #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8),
    .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(vld8)
  );

  rr_arbiter4 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4),
    .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(vld4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] gi,
                     input logic gv, input logic [3:0] eg, input logic [1:0] ei);
    checks++;
    assert (g === eg) else begin
      errors++;
      $error("FAIL %s gnt=%b expected %b", tag, g, eg);
    end
    checks++;
    assert (gv === (|eg)) else begin
      errors++;
      $error("FAIL %s gnt_valid=%b expected %b", tag, gv, |eg);
    end
    checks++;
    assert (gi === ei) else begin
      errors++;
      $error("FAIL %s gnt_idx=%0d expected %0d", tag, gi, ei);
    end
  endtask

  initial begin
    logic [3:0] eg;
    logic [1:0] ei;

    // Reset with all requests high: outputs stay cleared
    rst_n = 1'b0;
    req8  = 4'b1111;
    req4  = 4'b0000;
    step();
    chk("reset_a", gnt8, idx8, vld8, 4'b0000, 2'd0);
    step();
    chk("reset_b", gnt8, idx8, vld8, 4'b0000, 2'd0);
    rst_n = 1'b1;
    req8  = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle", gnt8, idx8, vld8, 4'b0000, 2'd0);
    end

    // Single requester holds for 20 cycles, no timeout
    req8 = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("single_hold", gnt8, idx8, vld8, 4'b0100, 2'd2);
    end
    req8 = 4'b0000;
    step();
    chk("single_drop", gnt8, idx8, vld8, 4'b0000, 2'd2);

    // Asynchronous reset restores pointer to 0
    rst_n = 1'b0;
    #1;
    chk("reset_async_idle", gnt8, idx8, vld8, 4'b0000, 2'd0);
    rst_n = 1'b1;

    // Fairness: each owner drops for one cycle after being granted
    req8 = 4'b1111;
    step();
    chk("rr_0", gnt8, idx8, vld8, 4'b0001, 2'd0);
    req8 = 4'b1110;
    step();
    chk("rr_1", gnt8, idx8, vld8, 4'b0010, 2'd1);
    req8 = 4'b1101;
    step();
    chk("rr_2", gnt8, idx8, vld8, 4'b0100, 2'd2);
    req8 = 4'b1011;
    step();
    chk("rr_3", gnt8, idx8, vld8, 4'b1000, 2'd3);
    req8 = 4'b0111;
    step();
    chk("rr_wrap0", gnt8, idx8, vld8, 4'b0001, 2'd0);
    req8 = 4'b0000;
    step();
    chk("rr_idle", gnt8, idx8, vld8, 4'b0000, 2'd0);

    // Wrap-around: owner 3 releases while 1 and 2 request
    req8 = 4'b1000;
    step();
    chk("wrap_own3", gnt8, idx8, vld8, 4'b1000, 2'd3);
    req8 = 4'b0110;
    step();
    chk("wrap_next1", gnt8, idx8, vld8, 4'b0010, 2'd1);

    // Reset in the middle of a grant to requester 2
    req8 = 4'b0100;
    step();
    chk("mid_own2", gnt8, idx8, vld8, 4'b0100, 2'd2);
    req8 = 4'b0110;
    step();
    chk("mid_hold2", gnt8, idx8, vld8, 4'b0100, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async", gnt8, idx8, vld8, 4'b0000, 2'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("mid_after", gnt8, idx8, vld8, 4'b0010, 2'd1);
    req8 = 4'b0000;
    step();
    chk("mid_drop", gnt8, idx8, vld8, 4'b0000, 2'd1);

    // Timeout rotation with hold limit 4 on requesters 0 and 3
    req4 = 4'b1001;
    for (int c = 0; c < 12; c++) begin
      step();
      if (((c / 4) % 2) == 0) begin
        eg = 4'b0001;
        ei = 2'd0;
      end else begin
        eg = 4'b1000;
        ei = 2'd3;
      end
      chk("timeout4", gnt4, idx4, vld4, eg, ei);
    end

    // Owner 0 drops; requester 1 alone never times out
    req4 = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("sole4", gnt4, idx4, vld4, 4'b0010, 2'd1);
    end
    req4 = 4'b0000;
    step();
    chk("sole4_drop", gnt4, idx4, vld4, 4'b0000, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
